// File: rtl/hamming_interleave.sv
// hamming_interleave: ping-pong block interleaver, DEPTH codewords in, CODED_WIDTH bit-columns out.
// Optional zero-pad flush of a partial block: define HAMMING_INTERLEAVE_FLUSH_EN.
module hamming_interleave #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int CODED_WIDTH = DATA_WIDTH + $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
`ifdef HAMMING_INTERLEAVE_FLUSH_EN
    input  logic                   flush_i,
`endif
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [CODED_WIDTH-1:0] in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DEPTH-1:0]       out_data_o,
    output logic                   out_last_o
);
    localparam int WW = $clog2(DEPTH);
    localparam int RW = $clog2(CODED_WIDTH);

    logic [CODED_WIDTH-1:0] bank_q [2][DEPTH];
    logic [1:0]    full_q, full_d;
    logic          wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [WW-1:0] wr_cnt_q, wr_cnt_d;
    logic [RW-1:0] rd_cnt_q, rd_cnt_d;
    logic          in_hs, out_hs, wr_done, rd_done;

    assign in_ready_o  = !full_q[wr_sel_q];
    assign out_valid_o = full_q[rd_sel_q];
    assign out_last_o  = out_valid_o && rd_cnt_q == RW'(CODED_WIDTH - 1);
    assign in_hs       = in_valid_i && in_ready_o;
    assign out_hs      = out_valid_o && out_ready_i;
    assign rd_done     = out_hs && out_last_o;

`ifdef HAMMING_INTERLEAVE_FLUSH_EN
    logic          flush_do;
    logic [WW:0]   pad_row;
    // A flush closes a partial block (including one started by this cycle's write)
    assign flush_do = flush_i && in_ready_o && (wr_cnt_q != '0 || in_hs);
    assign pad_row  = {1'b0, wr_cnt_q} + (WW + 1)'(in_hs);
    assign wr_done  = (in_hs && wr_cnt_q == WW'(DEPTH - 1)) || flush_do;
`else
    assign wr_done  = in_hs && wr_cnt_q == WW'(DEPTH - 1);
`endif

    // Column rd_cnt of the draining bank, forced to zero while idle
    always_comb begin
        out_data_o = '0;
        for (int d = 0; d < DEPTH; d++)
            out_data_o[d] = out_valid_o ? bank_q[rd_sel_q][d][rd_cnt_q] : 1'b0;
    end

    // Next-state for bank pointers, counters and full flags; fill and drain never share a bank
    always_comb begin
        full_d = full_q;
        if (rd_done) full_d[rd_sel_q] = 1'b0;
        if (wr_done) full_d[wr_sel_q] = 1'b1;
        wr_sel_d = wr_done ? !wr_sel_q : wr_sel_q;
        rd_sel_d = rd_done ? !rd_sel_q : rd_sel_q;
        wr_cnt_d = wr_done ? '0 : in_hs ? wr_cnt_q + 1'b1 : wr_cnt_q;
        rd_cnt_d = rd_done ? '0 : out_hs ? rd_cnt_q + 1'b1 : rd_cnt_q;
    end

    // Row storage; contents are qualified by the full flags so need no reset
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < DEPTH; r++)
            if (in_hs && wr_cnt_q == WW'(r)) bank_q[wr_sel_q][r] <= in_data_i;
`ifdef HAMMING_INTERLEAVE_FLUSH_EN
            else if (flush_do && r >= int'(pad_row)) bank_q[wr_sel_q][r] <= '0;
`endif
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end
endmodule

// File: tb/tb_hamming_interleave.sv
// tb_hamming_interleave: scoreboard bench for hamming_interleave (DEPTH=8, DATA_WIDTH=32).
module tb_hamming_interleave;
    localparam int DW = 32;
    localparam int DEPTH = 8;

    function automatic int coded_w(input int d);
        int p = 0;
        while ((1 << p) < d + p + 1) p++;
        return d + p + 1;
    endfunction
    localparam int CW = coded_w(DW);

    logic clk_i = 0, rst_n_i = 0, in_valid_i = 0, in_ready_o, out_valid_o, out_ready_i = 0, out_last_o;
    logic [CW-1:0]    in_data_i = '0;
    logic [DEPTH-1:0] out_data_o;
`ifdef HAMMING_INTERLEAVE_FLUSH_EN
    logic flush_i = 0;
`endif

    hamming_interleave #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
`ifdef HAMMING_INTERLEAVE_FLUSH_EN
        .flush_i(flush_i),
`endif
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o)
    );

    always #5 clk_i = !clk_i;

    int n_cmp = 0, n_err = 0, n_beats = 0, nw = 0, rdy_pct = 100;
    logic [DEPTH:0]   exp_q [$];
    logic [CW-1:0]    wbuf [DEPTH];
    logic             stall_prev = 0;
    logic [DEPTH-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] rnd();
        logic [63:0] r = {$urandom(), $urandom()};
        return r[CW-1:0];
    endfunction

    initial forever begin
        @(posedge clk_i);
        #1 out_ready_i = ($urandom_range(99) < rdy_pct);
    end

    // Monitor + transpose model: outputs compared, then accepted inputs recorded
    always @(negedge clk_i) begin
        if (!rst_n_i) stall_prev = 0;
        else begin
            logic [DEPTH:0] e;
            if (stall_prev) check("stable", out_data_o, prev_data);
            stall_prev = out_valid_o && !out_ready_i;
            prev_data = out_data_o;
            if (!out_valid_o) check("idle_out", {out_last_o, out_data_o}, 0);
            else if (out_ready_i) begin
                if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("beat", {out_last_o, out_data_o}, e);
                    n_beats++;
                end
            end
            if (in_valid_i && in_ready_o) begin
                wbuf[nw] = in_data_i;
                nw++;
            end
`ifdef HAMMING_INTERLEAVE_FLUSH_EN
            if (flush_i && in_ready_o && nw != 0) begin
                for (int r = nw; r < DEPTH; r++) wbuf[r] = '0;
                nw = DEPTH;
            end
`endif
            if (nw == DEPTH) begin
                for (int k = 0; k < CW; k++) begin
                    for (int d = 0; d < DEPTH; d++) e[d] = wbuf[d][k];
                    e[DEPTH] = (k == CW - 1);
                    exp_q.push_back(e);
                end
                nw = 0;
            end
        end
    end

    task automatic send_word(input logic [CW-1:0] w, input int pv);
        int t = 0;
        logic ok;
        while ($urandom_range(99) >= pv) begin @(posedge clk_i); #1; end
        in_valid_i = 1;
        in_data_i = w;
        do begin
            @(negedge clk_i);
            ok = in_ready_o;
            @(posedge clk_i); #1;
            t++;
        end while (!ok && t < 5000);
        if (!ok) check("send_ok", ok, 1);
        in_valid_i = 0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid_o) && t < 20000) begin @(negedge clk_i); t++; end
        check("drained", exp_q.size(), 0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, t, base, run;
        logic ok;
        logic [CW-1:0] one = 1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_in_ready", in_ready_o, 1);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_out_last", out_last_o, 0);
        rst_n_i = 1;
        @(posedge clk_i); #1;

        // one-hot words: beat k carries bit k of word k, valid the cycle after the last write
        for (int i = 0; i < DEPTH - 1; i++) send_word(one << i, 100);
        in_valid_i = 1;
        in_data_i = one << (DEPTH - 1);
        @(negedge clk_i);
        check("lat_pre", out_valid_o, 0);
        @(posedge clk_i); #1;
        in_valid_i = 0;
        @(negedge clk_i);
        check("lat_post", out_valid_o, 1);
        wait_drain();

        // two back-to-back blocks drain with no bubble
        fork
            for (int i = 0; i < 2 * DEPTH; i++) send_word(rnd(), 100);
            begin
                t = 0;
                @(negedge clk_i);
                while (!out_valid_o && t < 300) begin @(negedge clk_i); t++; end
                run = 0;
                while (out_valid_o && run < 300) begin run++; @(negedge clk_i); end
                check("stream_beats", run, 2 * CW);
            end
        join
        wait_drain();

        // backpressure: both banks fill, then input stalls
        rdy_pct = 0;
        @(posedge clk_i); #1;
        acc = 0;
        in_valid_i = 1;
        in_data_i = rnd();
        repeat (40) begin
            @(negedge clk_i);
            ok = in_ready_o;
            @(posedge clk_i); #1;
            if (ok) begin acc++; in_data_i = rnd(); end
        end
        in_valid_i = 0;
        check("stall_accepted", acc, 2 * DEPTH);
        check("stall_in_ready", in_ready_o, 0);
        rdy_pct = 100;
        t = 0;
        @(negedge clk_i);
        while (!(out_valid_o && out_ready_i && out_last_o) && t < 300) begin @(negedge clk_i); t++; end
        check("ready_at_last", in_ready_o, 0);
        @(negedge clk_i);
        check("ready_after_last", in_ready_o, 1);
        wait_drain();

        // random valid/ready
        rdy_pct = 50;
        base = n_beats;
        for (int i = 0; i < 200 * DEPTH; i++) send_word(rnd(), 50);
        wait_drain();
        check("rand_beats", n_beats - base, 200 * CW);
        rdy_pct = 100;

        // asynchronous reset mid-block
        base = n_beats;
        for (int i = 0; i < DEPTH + 5; i++) send_word(rnd(), 100);
        t = 0;
        while (n_beats < base + 10 && t < 300) begin @(negedge clk_i); t++; end
        #3 rst_n_i = 0;
        exp_q.delete();
        nw = 0;
        #1;
        check("arst_in_ready", in_ready_o, 1);
        check("arst_out_valid", out_valid_o, 0);
        check("arst_out_data", out_data_o, 0);
        check("arst_out_last", out_last_o, 0);
        @(posedge clk_i); #1 rst_n_i = 1;
        @(posedge clk_i); #1;
        base = n_beats;
        for (int i = 0; i < DEPTH; i++) send_word(rnd(), 100);
        wait_drain();
        check("post_rst_beats", n_beats - base, CW);

`ifdef HAMMING_INTERLEAVE_FLUSH_EN
        // flush a three-word block: every column reads 0b111
        base = n_beats;
        for (int i = 0; i < 3; i++) send_word('1, 100);
        flush_i = 1;
        @(posedge clk_i); #1 flush_i = 0;
        wait_drain();
        check("flush_beats", n_beats - base, CW);
        flush_i = 1;
        @(posedge clk_i); #1 flush_i = 0;
        @(negedge clk_i);
        check("flush_empty", out_valid_o, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
